pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised, elastic pipeline-stage register for the RISC-V datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a data payload and a separate control field using a valid/ready handshake.
//  A 2-entry skid buffer gives full throughput with no combinational path from out_ready to in_ready.
//  Flush squashes in-flight contents and forces control bits (RegWrite, MemWrite, ...) to zero.
// PARAMETERS
//  DATA_W      32  payload width (ALU result, read data, PC, ...)
//  CTRL_W      8   control-field width; forced to 0 whenever an entry is invalid
//  CLEAR_DATA  0   1 = data also zeroed on flush/drain; 0 = data held (saves enables)
// PORTS
//  clk         in   1       rising-edge clock
//  reset_n     in   1       asynchronous active-low reset
//  flush       in   1       squash all entries this cycle (branch mispredict, exception)
//  in_valid    in   1       upstream has a beat
//  in_ready    out  1       stage can accept; registered (= !skid_valid)
//  in_data     in   DATA_W  upstream payload
//  in_ctrl     in   CTRL_W  upstream control bits
//  out_valid   out  1       main entry holds a beat
//  out_ready   in   1       downstream consumes
//  out_data    out  DATA_W  main-entry payload
//  out_ctrl    out  CTRL_W  main-entry control; 0 when out_valid=0
//  occupancy   out  2       number of valid entries, 0..2
// BEHAVIOUR
//  - Reset (reset_n=0, asynchronous): all valids=0, ctrl=0, data=0, in_ready=1, occupancy=0.
//    Deassertion is synchronised by the top level; the block samples normally from the first edge after.
//  - acc = in_valid & in_ready; pop = out_valid & out_ready; all state updates on posedge clk.
//  - Latency: an accepted beat appears on out_* the next cycle if the main entry is empty or popped.
//  - Main entry update, checked in order:
//      empty           & acc -> load input
//      pop & skid_valid      -> load skid
//      pop & acc             -> load input
//      pop                   -> invalid
//  - Skid entry: loads the input when acc & main valid & !pop. It drains into main on the next pop.
//    It never loads while occupied, because in_ready=0 then.
//  - Ordering is strictly FIFO; the skid entry is always older than any new input.
//  - in_ready depends only on registered state. out_valid, out_data and out_ctrl come straight from registers.
//  - flush (highest priority after reset): both valids <- 0; both ctrl <- 0; data <- 0 if CLEAR_DATA.
//    A beat offered the same cycle is dropped, even though in_ready=1 was shown.
//    A pop in the same cycle still completes downstream. Next cycle: in_ready=1, occupancy=0.
//  - Whenever an entry becomes invalid (pop without refill, flush), its ctrl is written to 0.
//    Hence out_ctrl=0 whenever out_valid=0, so a bubble can never write the register file or memory.
//  - Held beat: while out_valid & !out_ready, out_data and out_ctrl are stable.
//  - occupancy = main_valid + skid_valid. The value 3 never occurs.
//  - Stall from either side: out_ready=0 with in_valid=1 fills to 2, then in_ready=0.
//    No beat is lost or duplicated.
// STRUCTURE
//  - Shared pkg riscv_pipe_pkg: typedef logic [1:0] occ_t.
//    Also the per-stage CTRL_W localparams: CTRL_W_IFID, CTRL_W_IDEX, CTRL_W_EXMEM, CTRL_W_MEMWB.
//  - Sub-module pipe_entry (DATA_W, CTRL_W, CLEAR_DATA).
//    One slot: valid/data/ctrl with load and clear inputs, async active-low reset.
//    Instantiated twice (main, skid); the top holds only the steering logic above.
// TESTING
//  1 Reset mid-stream at occupancy=2 with reset_n=0 -> valids, out_ctrl and occupancy = 0 immediately.
//    Then in_ready=1.
//  2 Streaming: out_ready=1, in_valid=1, data 0x1..0x10 -> out_data 0x1..0x10 one cycle later.
//    Throughput 1/cycle, occupancy <= 1.
//  3 Backpressure: out_ready=0 for 3 cycles while sending 0xA, 0xB, 0xC.
//    -> 0xA held, 0xB in skid, in_ready=0, 0xC held upstream. After release, out = A, B, C in order.
//  4 Flush at occupancy=2 with in_valid=1 (ctrl=0xFF) -> next cycle out_valid=0, out_ctrl=0x00, occupancy=0.
//    The offered beat is absent.
//  5 Flush together with pop -> popped beat counted once downstream; nothing follows.
//  6 Random valid/ready (10k cycles), scoreboard check.
//    -> Output sequence equals accepted sequence; out_ctrl=0 whenever !out_valid.
//    in_ready never depends on same-cycle out_ready.

Source files
------------

// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline-stage types and per-stage control widths.
// Imported by the elastic stage register and its slot sub-module.
package riscv_pipe_pkg;

   typedef logic [1:0] occ_t;

   localparam int CTRL_W_IFID  = 4;
   localparam int CTRL_W_IDEX  = 12;
   localparam int CTRL_W_EXMEM = 8;
   localparam int CTRL_W_MEMWB = 4;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready beat channel carrying a payload and a control field.
// master drives the beat, slave returns ready.
interface pipe_stage_skid_if #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8
);

   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (
      output valid,
      output data,
      output ctrl,
      input  ready
   );

   modport slave (
      input  valid,
      input  data,
      input  ctrl,
      output ready
   );

endinterface

// File: rtl/pipe_stage_skid_entry.sv
// One pipeline slot: valid, payload and control with load/clear.
// Clear zeroes ctrl so an invalid slot never carries live control bits.
module pipe_entry #(
   parameter int DATA_W     = 32,
   parameter int CTRL_W     = 8,
   parameter bit CLEAR_DATA = 1'b0
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_data,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
         if (CLEAR_DATA)
            data <= '0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= d_data;
         ctrl  <= d_ctrl;
      end
   end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer.
// in_ready comes only from skid state, so out_ready never reaches it.
module pipe_stage_skid
   import riscv_pipe_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int CTRL_W     = 8,
   parameter bit CLEAR_DATA = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 flush,
   pipe_stage_skid_if.slave     up,
   pipe_stage_skid_if.master    dn,
   output occ_t                 occupancy
);

   logic              m_valid;
   logic              s_valid;
   logic [DATA_W-1:0] m_data;
   logic [DATA_W-1:0] s_data;
   logic [CTRL_W-1:0] m_ctrl;
   logic [CTRL_W-1:0] s_ctrl;

   logic              acc;
   logic              pop;
   logic              m_load;
   logic              m_clear;
   logic              m_from_skid;
   logic              s_load;
   logic              s_clear;
   logic [DATA_W-1:0] m_d_data;
   logic [CTRL_W-1:0] m_d_ctrl;

   assign up.ready = !s_valid;
   assign acc      = up.valid & up.ready;
   assign pop      = m_valid & dn.ready;

   // Skid is always older than a new input, so it wins the refill.
   assign m_from_skid = pop & s_valid;
   assign m_load  = !flush &
                    ((!m_valid & acc) | (pop & (s_valid | acc)));
   assign m_clear = flush | (pop & !s_valid & !acc);
   assign s_load  = !flush & acc & m_valid & !pop;
   assign s_clear = flush | m_from_skid;

   assign m_d_data = m_from_skid ? s_data : up.data;
   assign m_d_ctrl = m_from_skid ? s_ctrl : up.ctrl;

   pipe_entry #(
      .DATA_W     (DATA_W),
      .CTRL_W     (CTRL_W),
      .CLEAR_DATA (CLEAR_DATA)
   ) u_main (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (m_load),
      .clear   (m_clear),
      .d_data  (m_d_data),
      .d_ctrl  (m_d_ctrl),
      .valid   (m_valid),
      .data    (m_data),
      .ctrl    (m_ctrl)
   );

   pipe_entry #(
      .DATA_W     (DATA_W),
      .CTRL_W     (CTRL_W),
      .CLEAR_DATA (CLEAR_DATA)
   ) u_skid (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (s_load),
      .clear   (s_clear),
      .d_data  (up.data),
      .d_ctrl  (up.ctrl),
      .valid   (s_valid),
      .data    (s_data),
      .ctrl    (s_ctrl)
   );

   assign dn.valid  = m_valid;
   assign dn.data   = m_data;
   assign dn.ctrl   = m_ctrl;
   assign occupancy = occ_t'({1'b0, m_valid}) + occ_t'({1'b0, s_valid});

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid against a 2-deep FIFO model.
// Model: queue of {ctrl,data}; accept when <2 held, flush empties it.
module tb_pipe_stage_skid;
   import riscv_pipe_pkg::*;

   localparam int DW = 32;
   localparam int CW = 8;

   logic clk;
   logic reset_n;
   logic flush;
   occ_t occupancy;

   pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) up ();
   pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) dn ();

   pipe_stage_skid #(
      .DATA_W     (DW),
      .CTRL_W     (CW),
      .CLEAR_DATA (1'b0)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .up        (up.slave),
      .dn        (dn.master),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [CW+DW-1:0] q[$];
   logic [DW-1:0]    obs[$];

   // One clock: update the model from the inputs the DUT sampled.
   task automatic cyc();
      int  n;
      logic mp, ma;
      @(posedge clk);
      n  = q.size();
      mp = (n > 0) && dn.ready;
      ma = up.valid && (n < 2);
      if (dn.valid && dn.ready)
         obs.push_back(dn.data);
      if (flush) begin
         q.delete();
      end else begin
         if (mp) void'(q.pop_front());
         if (ma) q.push_back({up.ctrl, up.data});
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d,
                        input logic [CW-1:0] c, input logic r);
      up.valid = v;
      up.data  = d;
      up.ctrl  = c;
      dn.ready = r;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      flush   = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      q.delete();
      #1;
      checks++;
      if (dn.valid !== 1'b0 || occupancy !== 2'd0 || up.ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state: valid=%b occ=%0d rdy=%b required 0/0/1",
                  dn.valid, occupancy, up.ready);
      end
      checks++;
      if (dn.ctrl !== 8'h00 || dn.data !== 32'h0) begin
         failures++;
         $display("FAIL reset_regs: ctrl=%h data=%h required 0/0",
                  dn.ctrl, dn.data);
      end
      @(negedge clk);
   endtask

   task automatic test_reset_midstream();
      drive(1'b1, 32'h71, 8'h5A, 1'b0);
      cyc();
      drive(1'b1, 32'h72, 8'h5B, 1'b0);
      cyc();
      checks++;
      if (occupancy !== 2'd2 || up.ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_fill: occ=%0d rdy=%b required 2/0",
                  occupancy, up.ready);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (dn.valid !== 1'b0 || dn.ctrl !== 8'h00 || occupancy !== 2'd0) begin
         failures++;
         $display("FAIL mid_reset: valid=%b ctrl=%h occ=%0d required 0/00/0",
                  dn.valid, dn.ctrl, occupancy);
      end
      checks++;
      if (up.ready !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_rdy: rdy=%b required 1", up.ready);
      end
      drive(1'b0, '0, '0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      q.delete();
      @(negedge clk);
   endtask

   task automatic test_streaming();
      for (int k = 1; k <= 16; k++) begin
         drive(1'b1, DW'(k), CW'(k * 3), 1'b1);
         cyc();
         checks++;
         if (dn.valid !== 1'b1 || dn.data !== DW'(k) || occupancy > 2'd1) begin
            failures++;
            $display("FAIL stream_%0d: valid=%b data=%h occ=%0d required 1/%h/<=1",
                     k, dn.valid, dn.data, occupancy, k);
         end
      end
      drive(1'b0, '0, '0, 1'b1);
      cyc();
      checks++;
      if (dn.valid !== 1'b0 || dn.ctrl !== 8'h00) begin
         failures++;
         $display("FAIL stream_drain: valid=%b ctrl=%h required 0/00",
                  dn.valid, dn.ctrl);
      end
   endtask

   task automatic test_backpressure();
      drive(1'b1, 32'hA, 8'h0A, 1'b0);
      cyc();
      drive(1'b1, 32'hB, 8'h0B, 1'b0);
      cyc();
      checks++;
      if (up.ready !== 1'b0 || occupancy !== 2'd2 || dn.data !== 32'hA) begin
         failures++;
         $display("FAIL bp_full: rdy=%b occ=%0d data=%h required 0/2/a",
                  up.ready, occupancy, dn.data);
      end
      drive(1'b1, 32'hC, 8'h0C, 1'b0);
      cyc();
      checks++;
      if (dn.data !== 32'hA || dn.ctrl !== 8'h0A || up.ready !== 1'b0) begin
         failures++;
         $display("FAIL bp_hold: data=%h ctrl=%h rdy=%b required a/0a/0",
                  dn.data, dn.ctrl, up.ready);
      end
      dn.ready = 1'b1;
      cyc();
      checks++;
      if (dn.data !== 32'hB || occupancy !== 2'd1 || up.ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_b: data=%h occ=%0d rdy=%b required b/1/1",
                  dn.data, occupancy, up.ready);
      end
      cyc();
      checks++;
      if (dn.data !== 32'hC || dn.ctrl !== 8'h0C || dn.valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_c: data=%h ctrl=%h valid=%b required c/0c/1",
                  dn.data, dn.ctrl, dn.valid);
      end
      up.valid = 1'b0;
      cyc();
      checks++;
      if (dn.valid !== 1'b0 || dn.ctrl !== 8'h00) begin
         failures++;
         $display("FAIL bp_empty: valid=%b ctrl=%h required 0/00",
                  dn.valid, dn.ctrl);
      end
   endtask

   task automatic test_flush_full();
      int n0;
      drive(1'b1, 32'h1, 8'h11, 1'b0);
      cyc();
      drive(1'b1, 32'h2, 8'h22, 1'b0);
      cyc();
      flush = 1'b1;
      drive(1'b1, 32'hDEAD, 8'hFF, 1'b0);
      cyc();
      flush = 1'b0;
      drive(1'b0, '0, '0, 1'b0);
      #1;
      checks++;
      if (dn.valid !== 1'b0 || dn.ctrl !== 8'h00 || occupancy !== 2'd0 ||
          up.ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_full: valid=%b ctrl=%h occ=%0d rdy=%b required 0/00/0/1",
                  dn.valid, dn.ctrl, occupancy, up.ready);
      end
      n0 = obs.size();
      dn.ready = 1'b1;
      cyc();
      cyc();
      checks++;
      if (dn.valid !== 1'b0 || obs.size() != n0) begin
         failures++;
         $display("FAIL flush_drop: valid=%b beats=%0d required 0/%0d",
                  dn.valid, obs.size(), n0);
      end
   endtask

   task automatic test_flush_pop();
      obs.delete();
      drive(1'b1, 32'h55, 8'h03, 1'b0);
      cyc();
      up.valid = 1'b0;
      dn.ready = 1'b1;
      flush    = 1'b1;
      cyc();
      flush = 1'b0;
      checks++;
      if (obs.size() != 1 || obs[0] !== 32'h55 || dn.valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_pop: beats=%0d valid=%b required 1 beat 55, valid 0",
                  obs.size(), dn.valid);
      end
      repeat (3) cyc();
      checks++;
      if (obs.size() != 1) begin
         failures++;
         $display("FAIL flush_pop_after: beats=%0d required 1", obs.size());
      end
   endtask

   task automatic test_random();
      logic [CW+DW-1:0] exp_q[$];
      logic [CW+DW-1:0] front;
      obs.delete();
      for (int i = 0; i < 10000; i++) begin
         drive($urandom_range(0, 3) != 0, $urandom, CW'($urandom),
               $urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 63) == 0);
         #1;
         front = (q.size() > 0) ? q[0] : '0;
         checks++;
         if (up.ready !== (q.size() < 2) || occupancy !== occ_t'(q.size())) begin
            failures++;
            $display("FAIL rnd_rdy_%0d: rdy=%b occ=%0d required %b/%0d",
                     i, up.ready, occupancy, q.size() < 2, q.size());
         end
         checks++;
         if (dn.valid !== (q.size() > 0)) begin
            failures++;
            $display("FAIL rnd_valid_%0d: valid=%b required %b",
                     i, dn.valid, q.size() > 0);
         end
         checks++;
         if (q.size() > 0 && {dn.ctrl, dn.data} !== front) begin
            failures++;
            $display("FAIL rnd_beat_%0d: beat=%h required %h",
                     i, {dn.ctrl, dn.data}, front);
         end
         checks++;
         if (!dn.valid && dn.ctrl !== 8'h00) begin
            failures++;
            $display("FAIL rnd_bubble_%0d: ctrl=%h required 00", i, dn.ctrl);
         end
         if (dn.valid && dn.ready && !flush) exp_q.push_back(front);
         cyc();
      end
      flush = 1'b0;
      drive(1'b0, '0, '0, 1'b1);
      repeat (3) cyc();
      checks++;
      if (dn.valid !== 1'b0 || occupancy !== 2'd0) begin
         failures++;
         $display("FAIL rnd_drain: valid=%b occ=%0d required 0/0",
                  dn.valid, occupancy);
      end
      checks++;
      if (obs.size() < exp_q.size()) begin
         failures++;
         $display("FAIL rnd_count: beats=%0d required >=%0d",
                  obs.size(), exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_reset_midstream();
      test_streaming();
      test_backpressure();
      test_flush_full();
      test_flush_pop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
